// File: rtl/bg_noise_subtractor.sv
// bg_noise_subtractor
//   Loads a per-lane accumulated background-noise sum and turns it into a
//   rounded per-period average. Each incoming period vector has that average
//   subtracted lane by lane. The unsaturated difference drives a threshold
//   detector, and the output is the difference saturated back to DATA_W bits.
//
//   state | meaning
//   IDLE  | no noise average loaded since reset; period vectors are refused
//   RUN   | average valid; vectors stream through the two-stage pipeline
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   noise_valid/ready     noise sum load handshake (ready = !rst)
//   noise_in              LANES x NOISE_W signed sums, lane i at [NOISE_W*i +: NOISE_W]
//   in_valid/ready        period vector handshake
//   in_data               LANES x DATA_W signed samples
//   out_valid/ready       result handshake
//   out_data              LANES x DATA_W saturated (data - avg)
//   out_hit               per-lane flag, unsaturated diff > THRESH
//   hit_any               out_valid & |out_hit
//   frame_cnt             number of output handshakes, wrapping
module bg_noise_subtractor #(
  parameter int LANES     = 16,
  parameter int DATA_W    = 8,
  parameter int NOISE_W   = 16,
  parameter int AVG_SHIFT = 4,
  parameter int THRESH    = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       noise_valid,
  output logic                       noise_ready,
  input  logic [LANES*NOISE_W-1:0]   noise_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DATA_W-1:0]    out_data,
  output logic [LANES-1:0]           out_hit,
  output logic                       hit_any,
  output logic [15:0]                frame_cnt
);

  localparam int DW = NOISE_W + 1;
  localparam logic signed [DW-1:0]     RND      = DW'(2 ** (AVG_SHIFT - 1));
  localparam logic signed [DW-1:0]     THRESH_X = DW'(THRESH);
  localparam logic signed [DW-1:0]     SAT_MAX  = DW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [DW-1:0]     SAT_MIN  = DW'(-(2 ** (DATA_W - 1)));
  localparam logic signed [DATA_W-1:0] OUT_MAX  = DATA_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [DATA_W-1:0] OUT_MIN  = DATA_W'(-(2 ** (DATA_W - 1)));

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic signed [NOISE_W-1:0] avg       [LANES];
  logic signed [DW-1:0]      s1_diff   [LANES];
  logic                      s1_v;

  logic signed [DW-1:0]      noise_rnd [LANES];
  logic signed [NOISE_W-1:0] avg_next  [LANES];
  logic signed [DW-1:0]      diff_next [LANES];
  logic signed [DATA_W-1:0]  sat_next  [LANES];
  logic [LANES-1:0]          hit_next;

  logic load;
  logic in_fire;
  logic s2_load;

  assign noise_ready = !rst;
  assign load        = noise_valid & noise_ready;
  // Two slots (S1, output reg); a new vector fits if either slot is free or
  // the output is draining this cycle.
  assign in_ready    = !rst & (state == RUN) & (!s1_v | !out_valid | out_ready);
  assign in_fire     = in_valid & in_ready;
  assign s2_load     = s1_v & (!out_valid | out_ready);
  assign hit_any     = out_valid & (|out_hit);

  always_comb begin
    hit_next = '0;
    for (int i = 0; i < LANES; i++) begin
      // One extra bit so the rounding bias cannot overflow the sum.
      noise_rnd[i] = $signed({noise_in[NOISE_W*i + NOISE_W-1], noise_in[NOISE_W*i +: NOISE_W]}) + RND;
      avg_next[i]  = NOISE_W'(noise_rnd[i] >>> AVG_SHIFT);
      diff_next[i] = $signed({{(DW-DATA_W){in_data[DATA_W*i + DATA_W-1]}}, in_data[DATA_W*i +: DATA_W]})
                   - $signed({avg[i][NOISE_W-1], avg[i]});
      if (s1_diff[i] > SAT_MAX)
        sat_next[i] = OUT_MAX;
      else if (s1_diff[i] < SAT_MIN)
        sat_next[i] = OUT_MIN;
      else
        sat_next[i] = s1_diff[i][DATA_W-1:0];
      hit_next[i] = (s1_diff[i] > THRESH_X);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s1_v      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_hit   <= '0;
      frame_cnt <= '0;
      for (int i = 0; i < LANES; i++) begin
        avg[i]     <= '0;
        s1_diff[i] <= '0;
      end
    end else begin
      case (state)
        IDLE:    if (load) state <= RUN;
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase

      // A vector accepted alongside a load sees the old average because
      // diff_next reads avg before this edge updates it.
      if (load) begin
        for (int i = 0; i < LANES; i++) avg[i] <= avg_next[i];
      end

      if (in_fire) begin
        for (int i = 0; i < LANES; i++) s1_diff[i] <= diff_next[i];
      end
      s1_v <= in_fire | (s1_v & !s2_load);

      if (s2_load) begin
        for (int i = 0; i < LANES; i++) out_data[DATA_W*i +: DATA_W] <= sat_next[i];
        out_hit <= hit_next;
      end
      out_valid <= s2_load | (out_valid & !out_ready);

      if (out_valid & out_ready) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
